// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory req/gnt/r_valid port between instruction fetch
//            and data load/store; optional ARB_ROUND_ROBIN_EN adds a toggling
//            priority pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 2
) (
    input  logic          CLK,
    input  logic          RES_N,

    input  logic          instr_req,
    input  logic [AW-1:0] instr_addr,
    output logic          instr_gnt,
    output logic          instr_r_valid,
    output logic [DW-1:0] instr_rdata,

    input  logic          data_req,
    input  logic          data_we,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_gnt,
    output logic          data_r_valid,
    output logic [DW-1:0] data_rdata,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_r_valid,
    input  logic [DW-1:0] mem_rdata,

    output logic          proto_err
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic               lock_q,  lock_d;
    logic               owner_q, owner_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      wr_q,    wr_d;
    logic [PW-1:0]      rd_q,    rd_d;
    logic [MAX_OUT-1:0] fifo_q,  fifo_d;
    logic               err_q,   err_d;

    logic sel_data;
    logic sel_req;
    logic not_full;
    logic empty;
    logic hs;
    logic pop;
    logic head;
    logic prio_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_q;

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            prio_q <= 1'b1;
        end else if (hs) begin
            prio_q <= ~sel_data;
        end
    end

    assign prio_data = prio_q;
`else
    assign prio_data = 1'b1;
`endif

    // A stalled request keeps the port until the memory accepts it.
    always_comb begin
        if (lock_q) begin
            sel_data = owner_q;
        end else if (data_req && instr_req) begin
            sel_data = prio_data;
        end else begin
            sel_data = data_req;
        end
    end

    assign sel_req  = sel_data ? data_req : instr_req;
    assign not_full = (count_q != CW'(MAX_OUT));
    assign empty    = (count_q == '0);

    assign mem_req   = RES_N & sel_req & not_full;
    assign mem_we    = mem_req & sel_data & data_we;
    assign mem_addr  = mem_req ? (sel_data ? data_addr : instr_addr) : '0;
    assign mem_wdata = (mem_req & sel_data) ? data_wdata : '0;

    assign hs        = mem_req & mem_gnt;
    assign instr_gnt = hs & ~sel_data;
    assign data_gnt  = hs & sel_data;

    // Responses with nothing outstanding are dropped rather than routed.
    assign pop           = RES_N & mem_r_valid & ~empty;
    assign head          = fifo_q[rd_q];
    assign instr_r_valid = pop & ~head;
    assign data_r_valid  = pop & head;
    assign instr_rdata   = instr_r_valid ? mem_rdata : '0;
    assign data_rdata    = data_r_valid  ? mem_rdata : '0;
    assign proto_err     = err_q;

    always_comb begin
        lock_d  = mem_req & ~mem_gnt;
        owner_d = lock_d ? sel_data : owner_q;
        fifo_d  = fifo_q;
        if (hs) begin
            fifo_d[wr_q] = sel_data;
        end
        wr_d    = hs  ? ptr_inc(wr_q) : wr_q;
        rd_d    = pop ? ptr_inc(rd_q) : rd_q;
        count_d = count_q + CW'(hs) - CW'(pop);
        err_d   = err_q | (mem_r_valid & empty);
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            lock_q  <= 1'b0;
            owner_q <= 1'b0;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            fifo_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fifo_q  <= fifo_d;
            err_q   <= err_d;
        end
    end

endmodule

`default_nettype wire
